multi_clock_divider: RTL
========================

Name: multi_clock_divider

Overview:
Multi-channel programmable clock divider: NUM_CH independent divided clocks from one system clock. Each channel has a run-time programmable period and high-time (duty cycle), a per-channel enable, and a one-cycle tick strobe at the start of each period. New settings are double-buffered and take effect only at a period boundary, so outputs never glitch. It feeds LED, PWM and display-scan logic in place of fixed single-output dividers.

Parameters:
NUM_CH, 4, number of independent channels (1..16)
CNT_W, 26, width of the period, high-time and counter registers
RST_PERIOD, 50000000, period value loaded into every channel at reset
RST_HIGH, 25000000, high-time value loaded into every channel at reset
CH_W, $clog2(NUM_CH) (minimum 1), width of the channel index

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high; clears all state
cfg_valid  in  1  configuration write request
cfg_ch  in  CH_W  target channel of the write
cfg_period  in  CNT_W  new period in clk cycles
cfg_high  in  CNT_W  new high-time in clk cycles
cfg_ready  out  1  write accepted this cycle when cfg_valid & cfg_ready
en  in  NUM_CH  per-channel run enable
outClk  out  NUM_CH  divided clock outputs, registered
tick  out  NUM_CH  one-cycle pulse at the start of each period, registered

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset state:
  - every counter = 0; active period = RST_PERIOD; active high = RST_HIGH
  - all pending flags cleared; outClk = 0; tick = 0
  - reset in mid-operation drops any pending configuration
- Per-channel state: counter c, active period P, active high H, shadow period/high, pending flag.
- Effective period Pe = max(P, 2). A programmed period of 0 or 1 behaves as 2.
- Counting (en[i]=1): c increments each cycle. When c == Pe-1, c wraps to 0 on the next edge.
- Outputs (one cycle of latency):
  - if c holds value v in cycle n, then in cycle n+1 outClk[i] = (v < H) and tick[i] = (v == 0)
  - H=0 gives a constant low output; H >= Pe gives a constant high output
  - tick still pulses once per period in both cases
- en[i]=0:
  - c is held at 0; outClk[i] and tick[i] are 0 from the next cycle
  - on the rising edge of en, the first counted value is c=0, so the first tick and the high phase appear one cycle after en rises
- Configuration handshake:
  - cfg_ready = ~pending[cfg_ch] (combinational)
  - cfg_ch >= NUM_CH: cfg_ready = 1 and the write is accepted and discarded
  - on accept, the shadow registers are loaded and pending is set
- Applying a pending configuration:
  - while the channel is counting, shadow→active transfer happens at the first wrap strictly after the acceptance cycle; c goes to 0, pending clears, and cfg_ready rises again the next cycle
  - if accept and wrap occur on the same edge, the new values apply at the following wrap, never the current one
  - if the channel is disabled, the transfer happens on the edge after acceptance
- Channel independence: channels never interact. Writes to one channel do not disturb the counters of the others.
- Arithmetic: all compares are unsigned at CNT_W bits. Counters never exceed Pe-1, and no division is used.

Test Plan:
- Reset, then enable ch0 with cfg {P=4, H=2} written while disabled → after en rises, outClk[0] shows the pattern 1,1,0,0 repeating; tick[0] pulses every 4 cycles, aligned with the first high cycle.
- Ch1 running {P=10, H=5}; write {P=6, H=1} mid-period (c=3) → the remaining 10-cycle period completes unchanged, then the 6-cycle period with 1 high cycle starts. cfg_ready[ch1] is low from the cycle after acceptance until the cycle after the wrap; a second write in that window is stalled.
- Write that lands exactly on the wrap edge of a channel with {P=8} → one further 8-cycle period runs, then the new values apply.
- Boundary values on ch2: {P=0, H=1} → period of 2, 50% duty. {P=5, H=0} → outClk constant 0, tick every 5 cycles. {P=5, H=7} → outClk constant 1.
- All four channels enabled with distinct periods {3, 4, 5, 7} → every output matches its own reference model over 420 cycles. Deasserting en[1] for 10 cycles does not perturb the other channels.
- Reset asserted mid-period with a write pending → the next cycle shows all outputs 0, pending cleared, cfg_ready = 1, and channels resume at RST_PERIOD/RST_HIGH. A write with cfg_ch = NUM_CH is accepted and has no effect.

Source files
------------

// File: rtl/multi_clock_divider.sv
// Multi-channel programmable clock divider: per-channel period/high-time with
// double-buffered configuration that only takes effect at a period boundary.
module multi_clock_divider #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CNT_W      = 26,
    parameter int unsigned RST_PERIOD = 50000000,
    parameter int unsigned RST_HIGH   = 25000000,
    localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_high,
    output logic              cfg_ready,
    input  logic [NUM_CH-1:0] en,
    output logic [NUM_CH-1:0] outClk,
    output logic [NUM_CH-1:0] tick
);

    logic [NUM_CH-1:0] pend_vec;

    // Out-of-range channel indices are always ready so such writes drain harmlessly.
    always_comb begin
        cfg_ready = 1'b1;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (cfg_ch == CH_W'(k)) begin
                cfg_ready = ~pend_vec[k];
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt_q,   cnt_d;
        logic [CNT_W-1:0] per_q,   per_d;
        logic [CNT_W-1:0] high_q,  high_d;
        logic [CNT_W-1:0] sper_q,  sper_d;
        logic [CNT_W-1:0] shigh_q, shigh_d;
        logic             pend_q,  pend_d;
        logic             out_q,   out_d;
        logic             tick_q,  tick_d;
        logic             acc_c;
        logic             wrap_c;
        logic [CNT_W-1:0] last_c;

        // Periods below 2 behave as 2, so the last count is never below 1.
        always_comb begin
            acc_c  = cfg_valid & (cfg_ch == CH_W'(i)) & ~pend_q;
            last_c = (per_q < CNT_W'(2)) ? CNT_W'(1) : per_q - CNT_W'(1);
            wrap_c = en[i] & (cnt_q == last_c);
        end

        always_comb begin
            cnt_d   = cnt_q;
            per_d   = per_q;
            high_d  = high_q;
            sper_d  = sper_q;
            shigh_d = shigh_q;
            pend_d  = pend_q;
            out_d   = 1'b0;
            tick_d  = 1'b0;

            if (en[i]) begin
                out_d  = (cnt_q < high_q);
                tick_d = (cnt_q == '0);
                cnt_d  = wrap_c ? '0 : cnt_q + CNT_W'(1);
            end else begin
                cnt_d = '0;
            end

            // pend_q only reflects writes accepted on an earlier edge, so a write
            // coinciding with a wrap waits for the following wrap.
            if (pend_q && (wrap_c || !en[i])) begin
                per_d  = sper_q;
                high_d = shigh_q;
                pend_d = 1'b0;
            end

            if (acc_c) begin
                sper_d  = cfg_period;
                shigh_d = cfg_high;
                pend_d  = 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q   <= '0;
                per_q   <= CNT_W'(RST_PERIOD);
                high_q  <= CNT_W'(RST_HIGH);
                sper_q  <= CNT_W'(RST_PERIOD);
                shigh_q <= CNT_W'(RST_HIGH);
                pend_q  <= 1'b0;
                out_q   <= 1'b0;
                tick_q  <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                per_q   <= per_d;
                high_q  <= high_d;
                sper_q  <= sper_d;
                shigh_q <= shigh_d;
                pend_q  <= pend_d;
                out_q   <= out_d;
                tick_q  <= tick_d;
            end
        end

        assign pend_vec[i] = pend_q;
        assign outClk[i]   = out_q;
        assign tick[i]     = tick_q;
    end

endmodule
